load_align_unit: RTL and testbench

- Read-side counterpart of the store packer in the MEM stage. It accepts LB/LBU/LH/LHU/LW requests and issues word reads to the synchronous-read data memory.
- Merges and extracts the addressed bytes, then sign- or zero-extends them to 32 bits for writeback.
- Misaligned accesses that straddle a word boundary are split into two reads with a one-cycle pipeline stall.
- Sits between MEM control and the dmem read port. Its result feeds the WB data mux.

---
 rtl/load_align_unit.sv | 120 ++++++++++++
 tb/tb_load_align_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_align_unit.sv
// Load alignment unit: issues dmem word reads for LB/LBU/LH/LHU/LW and returns the
// extracted, sign/zero-extended data; loads straddling a word boundary take two beats.
module load_align_unit #(
   parameter int ADDR_W           = 14,
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [31:0]       req_addr,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_dout,
   output logic              rsp_valid,
   output logic [31:0]       rsp_data,
   output logic              stall,
   output logic              misaligned_fault
);

   typedef enum logic [1:0] {IDLE, ISSUED, SPLIT} state_t;

   localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

   state_t              state;
   logic [1:0]          off_q;
   logic [1:0]          size_q;
   logic                signed_q;
   logic                merge_q;
   logic                fault_q;
   logic [ADDR_W-1:0]   waddr_q;
   logic [31:0]         beat0_q;
   logic [31:0]         last_q;

   logic [1:0]          off;
   logic [2:0]          nbytes;
   logic                straddle;
   logic                accept;
   logic [ADDR_W-1:0]   waddr;
   logic [63:0]         window;
   logic [31:0]         field;
   logic [31:0]         extended;
   logic [31:0]         result;
   logic                unused_addr_bits;

   assign off              = req_addr[1:0];
   assign waddr            = req_addr[ADDR_W+1:2];
   assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

   always_comb begin
      case (req_size)
         2'd0:    nbytes = 3'd1;
         2'd1:    nbytes = 3'd2;
         default: nbytes = 3'd4;
      endcase
   end

   assign straddle  = ({1'b0, off} + nbytes) > 3'd4;
   assign req_ready = (state != SPLIT);
   // Gate acceptance with reset so no read is launched while the unit is held in reset.
   assign accept    = rst & req_valid & req_ready;
   assign stall     = (state == SPLIT);

   assign mem_en   = (state == SPLIT) | accept;
   assign mem_addr = (state == SPLIT) ? (waddr_q + ONE) : (accept ? waddr : '0);

   // The second beat is the high word of the window; single-beat reads leave it zero.
   assign window = merge_q ? {mem_dout, beat0_q} : {32'd0, mem_dout};
   assign field  = 32'(window >> {off_q, 3'b000});

   always_comb begin
      case (size_q)
         2'd0:    extended = {{24{signed_q & field[7]}}, field[7:0]};
         2'd1:    extended = {{16{signed_q & field[15]}}, field[15:0]};
         default: extended = field;
      endcase
   end

   assign result           = fault_q ? 32'd0 : extended;
   assign rsp_valid        = (state == ISSUED);
   assign rsp_data         = rsp_valid ? result : last_q;
   assign misaligned_fault = rsp_valid & fault_q;

   // Request capture and beat sequencing; SPLIT always hands over to ISSUED to merge beat1.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         off_q    <= '0;
         size_q   <= '0;
         signed_q <= 1'b0;
         merge_q  <= 1'b0;
         fault_q  <= 1'b0;
         waddr_q  <= '0;
         beat0_q  <= '0;
         last_q   <= '0;
      end else if (state == SPLIT) begin
         beat0_q <= mem_dout;
         merge_q <= 1'b1;
         state   <= ISSUED;
      end else begin
         if (rsp_valid) begin
            last_q <= result;
         end
         if (accept) begin
            off_q    <= off;
            size_q   <= req_size;
            signed_q <= req_signed;
            waddr_q  <= waddr;
            merge_q  <= 1'b0;
            fault_q  <= straddle & !ALLOW_MISALIGNED;
            state    <= (straddle && ALLOW_MISALIGNED) ? SPLIT : ISSUED;
         end else begin
            state <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_load_align_unit.sv
// Testbench for load_align_unit: directed scenarios on both misalignment modes plus a
// randomized stream checked against a byte-addressed reference model of the memory.
module tb_load_align_unit;

   localparam int AW = 14;

   typedef struct {
      int          due;
      logic [31:0] data;
   } rsp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic [31:0]   req_addr = '0;
   logic [1:0]    req_size = '0;
   logic          req_signed = 1'b0;

   logic          ready_a, mem_en_a, rsp_valid_a, stall_a, fault_a;
   logic [AW-1:0] mem_addr_a;
   logic [31:0]   dout_a = '0, rsp_data_a;
   logic          ready_b, mem_en_b, rsp_valid_b, stall_b, fault_b;
   logic [AW-1:0] mem_addr_b;
   logic [31:0]   dout_b = '0, rsp_data_b;

   logic [31:0]   dmem [0:(1<<AW)-1];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   load_align_unit #(.ADDR_W(AW), .ALLOW_MISALIGNED(1'b1)) dut_a (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_a),
      .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
      .mem_en(mem_en_a), .mem_addr(mem_addr_a), .mem_dout(dout_a),
      .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a), .stall(stall_a),
      .misaligned_fault(fault_a)
   );

   load_align_unit #(.ADDR_W(AW), .ALLOW_MISALIGNED(1'b0)) dut_b (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_b),
      .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
      .mem_en(mem_en_b), .mem_addr(mem_addr_b), .mem_dout(dout_b),
      .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .stall(stall_b),
      .misaligned_fault(fault_b)
   );

   // Synchronous-read data memory, one read port per DUT.
   always @(posedge clk) begin
      if (mem_en_a) dout_a <= dmem[mem_addr_a];
      if (mem_en_b) dout_b <= dmem[mem_addr_b];
   end

   // Reference load: gather bytes from a byte-addressed view of memory, then extend.
   function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size,
                                            input logic sgn);
      int          n;
      int          b;
      logic [31:0] w;
      logic [31:0] v;
      n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      v = '0;
      for (int i = 0; i < n; i++) begin
         b = (int'(addr[15:0]) + i) % 65536;
         w = dmem[b / 4];
         v = v | (((w >> (8 * (b % 4))) & 32'hFF) << (8 * i));
      end
      if (sgn && n == 1 && v[7])  v = v | 32'hFFFFFF00;
      if (sgn && n == 2 && v[15]) v = v | 32'hFFFF0000;
      return v;
   endfunction

   task automatic drive(input logic v, input logic [31:0] a, input logic [1:0] s, input logic sg);
      @(posedge clk);
      #1;
      req_valid  = v;
      req_addr   = a;
      req_size   = s;
      req_signed = sg;
      @(negedge clk);
   endtask

   task automatic test_reset;
      req_valid = 1'b1;
      req_addr  = 32'h4;
      req_size  = 2'd2;
      #1 rst = 1'b0;
      #2;
      n_checks++; if (rsp_valid_a !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rsp_valid: got %0b expected 0", rsp_valid_a); end
      n_checks++; if (rsp_data_a !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_rsp_data: got %h expected 00000000", rsp_data_a); end
      n_checks++; if (stall_a !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_stall: got %0b expected 0", stall_a); end
      n_checks++; if (fault_a !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_fault: got %0b expected 0", fault_a); end
      n_checks++; if (mem_en_a !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mem_en: got %0b expected 0", mem_en_a); end
      n_checks++; if (mem_addr_a !== 14'h0) begin n_fail++; $display("[TB] FAIL reset_mem_addr: got %h expected 0000", mem_addr_a); end
      req_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, 32'h0, 2'd0, 1'b0);
   endtask

   task automatic test_byte_half;
      logic [31:0] addrs [4] = '{32'h7, 32'h7, 32'h3, 32'h1};
      logic [1:0]  sizes [4] = '{2'd0, 2'd0, 2'd0, 2'd1};
      logic        sgns  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      logic [31:0] exps  [4] = '{32'hFFFFFF88, 32'h00000088, 32'h00000044, 32'h00003322};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, addrs[i], sizes[i], sgns[i]);
         n_checks++; if (mem_addr_a !== addrs[i][15:2]) begin n_fail++; $display("[TB] FAIL bh_mem_addr[%0d]: got %h expected %h", i, mem_addr_a, addrs[i][15:2]); end
         drive(1'b0, 32'h0, 2'd0, 1'b0);
         n_checks++; if (rsp_valid_a !== 1'b1) begin n_fail++; $display("[TB] FAIL bh_rsp_valid[%0d]: got %0b expected 1", i, rsp_valid_a); end
         n_checks++; if (rsp_data_a !== exps[i]) begin n_fail++; $display("[TB] FAIL bh_rsp_data[%0d]: got %h expected %h", i, rsp_data_a, exps[i]); end
      end
      drive(1'b0, 32'h0, 2'd0, 1'b0);
      n_checks++; if (rsp_data_a !== 32'h00003322) begin n_fail++; $display("[TB] FAIL bh_hold: got %h expected 00003322", rsp_data_a); end
   endtask

   task automatic test_back_to_back;
      drive(1'b1, 32'h4, 2'd2, 1'b0);
      n_checks++; if (mem_addr_a !== 14'h1) begin n_fail++; $display("[TB] FAIL b2b_addr0: got %h expected 0001", mem_addr_a); end
      drive(1'b1, 32'h0, 2'd2, 1'b0);
      n_checks++; if (rsp_data_a !== 32'h88776655 || rsp_valid_a !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_rsp0: got %0b/%h expected 1/88776655", rsp_valid_a, rsp_data_a); end
      n_checks++; if (mem_addr_a !== 14'h0 || ready_a !== 1'b1 || stall_a !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_issue1: got addr %h ready %0b stall %0b expected 0000/1/0", mem_addr_a, ready_a, stall_a); end
      drive(1'b0, 32'h0, 2'd0, 1'b0);
      n_checks++; if (rsp_data_a !== 32'h44332211 || rsp_valid_a !== 1'b1 || stall_a !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_rsp1: got %0b/%h stall %0b expected 1/44332211/0", rsp_valid_a, rsp_data_a, stall_a); end
      drive(1'b0, 32'h0, 2'd0, 1'b0);
      n_checks++; if (rsp_valid_a !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_idle: got %0b expected 0", rsp_valid_a); end
   endtask

   task automatic test_split;
      drive(1'b1, 32'h3, 2'd1, 1'b0);
      n_checks++; if (mem_addr_a !== 14'h0 || stall_a !== 1'b0) begin n_fail++; $display("[TB] FAIL lhu_beat0: got addr %h stall %0b expected 0000/0", mem_addr_a, stall_a); end
      drive(1'b1, 32'h4, 2'd2, 1'b0);
      n_checks++; if (stall_a !== 1'b1 || ready_a !== 1'b0 || mem_en_a !== 1'b1 || mem_addr_a !== 14'h1) begin n_fail++; $display("[TB] FAIL lhu_beat1: got stall %0b ready %0b en %0b addr %h expected 1/0/1/0001", stall_a, ready_a, mem_en_a, mem_addr_a); end
      n_checks++; if (rsp_valid_a !== 1'b0) begin n_fail++; $display("[TB] FAIL lhu_no_early_rsp: got %0b expected 0", rsp_valid_a); end
      drive(1'b0, 32'h0, 2'd0, 1'b0);
      n_checks++; if (rsp_valid_a !== 1'b1 || rsp_data_a !== 32'h00005544 || stall_a !== 1'b0) begin n_fail++; $display("[TB] FAIL lhu_rsp: got %0b/%h stall %0b expected 1/00005544/0", rsp_valid_a, rsp_data_a, stall_a); end
      drive(1'b0, 32'h0, 2'd0, 1'b0);
      n_checks++; if (rsp_valid_a !== 1'b0) begin n_fail++; $display("[TB] FAIL lhu_ignored_req: got %0b expected 0", rsp_valid_a); end
   endtask

   task automatic test_split_word_wrap;
      drive(1'b1, 32'h2, 2'd2, 1'b0);
      drive(1'b0, 32'h0, 2'd0, 1'b0);
      n_checks++; if (stall_a !== 1'b1 || mem_addr_a !== 14'h1) begin n_fail++; $display("[TB] FAIL lw2_beat1: got stall %0b addr %h expected 1/0001", stall_a, mem_addr_a); end
      drive(1'b1, 32'hFFFE, 2'd2, 1'b0);
      n_checks++; if (rsp_valid_a !== 1'b1 || rsp_data_a !== 32'h66554433) begin n_fail++; $display("[TB] FAIL lw2_rsp: got %0b/%h expected 1/66554433", rsp_valid_a, rsp_data_a); end
      n_checks++; if (ready_a !== 1'b1 || mem_addr_a !== 14'h3FFF) begin n_fail++; $display("[TB] FAIL wrap_beat0: got ready %0b addr %h expected 1/3fff", ready_a, mem_addr_a); end
      drive(1'b0, 32'h0, 2'd0, 1'b0);
      n_checks++; if (stall_a !== 1'b1 || mem_addr_a !== 14'h0 || rsp_valid_a !== 1'b0) begin n_fail++; $display("[TB] FAIL wrap_beat1: got stall %0b addr %h rsp %0b expected 1/0000/0", stall_a, mem_addr_a, rsp_valid_a); end
      drive(1'b1, 32'h0, 2'd2, 1'b0);
      n_checks++; if (rsp_valid_a !== 1'b1 || rsp_data_a !== 32'h2211DDCC) begin n_fail++; $display("[TB] FAIL wrap_rsp: got %0b/%h expected 1/2211ddcc", rsp_valid_a, rsp_data_a); end
      drive(1'b0, 32'h0, 2'd0, 1'b0);
      n_checks++; if (rsp_valid_a !== 1'b1 || rsp_data_a !== 32'h44332211) begin n_fail++; $display("[TB] FAIL after_split_rsp: got %0b/%h expected 1/44332211", rsp_valid_a, rsp_data_a); end
      drive(1'b0, 32'h0, 2'd0, 1'b0);
   endtask

   task automatic test_no_misaligned;
      drive(1'b1, 32'h2, 2'd2, 1'b0);
      n_checks++; if (stall_b !== 1'b0 || fault_b !== 1'b0 || mem_addr_b !== 14'h0) begin n_fail++; $display("[TB] FAIL nomis_issue: got stall %0b fault %0b addr %h expected 0/0/0000", stall_b, fault_b, mem_addr_b); end
      drive(1'b0, 32'h0, 2'd0, 1'b0);
      n_checks++; if (rsp_valid_b !== 1'b1 || rsp_data_b !== 32'h0 || fault_b !== 1'b1 || stall_b !== 1'b0) begin n_fail++; $display("[TB] FAIL nomis_rsp: got v %0b d %h fault %0b stall %0b expected 1/00000000/1/0", rsp_valid_b, rsp_data_b, fault_b, stall_b); end
      drive(1'b0, 32'h0, 2'd0, 1'b0);
      n_checks++; if (fault_b !== 1'b0 || rsp_valid_b !== 1'b0) begin n_fail++; $display("[TB] FAIL nomis_pulse: got fault %0b v %0b expected 0/0", fault_b, rsp_valid_b); end
      drive(1'b0, 32'h0, 2'd0, 1'b0);
   endtask

   task automatic test_reset_mid_split;
      drive(1'b1, 32'h2, 2'd2, 1'b0);
      @(posedge clk);
      #1 req_valid = 1'b0;
      #1 rst = 1'b0;
      #1;
      n_checks++; if (stall_a !== 1'b0 || rsp_valid_a !== 1'b0) begin n_fail++; $display("[TB] FAIL midsplit_abort: got stall %0b rsp %0b expected 0/0", stall_a, rsp_valid_a); end
      @(negedge clk);
      rst = 1'b1;
      drive(1'b1, 32'h0, 2'd2, 1'b0);
      n_checks++; if (rsp_valid_a !== 1'b0 || rsp_data_a !== 32'h0 || mem_addr_a !== 14'h0) begin n_fail++; $display("[TB] FAIL midsplit_restart: got v %0b d %h addr %h expected 0/00000000/0000", rsp_valid_a, rsp_data_a, mem_addr_a); end
      drive(1'b0, 32'h0, 2'd0, 1'b0);
      n_checks++; if (rsp_valid_a !== 1'b1 || rsp_data_a !== 32'h44332211) begin n_fail++; $display("[TB] FAIL midsplit_rsp: got %0b/%h expected 1/44332211", rsp_valid_a, rsp_data_a); end
      drive(1'b0, 32'h0, 2'd0, 1'b0);
   endtask

   task automatic test_random;
      rsp_t          pend [$];
      rsp_t          r;
      logic          model_stall;
      logic [AW-1:0] split_wa;
      logic [AW-1:0] exp_wa;
      logic [31:0]   exp_last;
      logic [31:0]   a;
      logic          exp_rv;
      int            n;
      logic [15:0]   hot [6] = '{16'h0, 16'h1, 16'h2, 16'h3, 16'h3FFE, 16'h3FFF};
      @(posedge clk);
      #1 req_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      model_stall = 1'b0;
      split_wa    = '0;
      exp_last    = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         a = $urandom;
         if ($urandom_range(1, 0) == 1) a[15:2] = hot[$urandom_range(5, 0)][13:0];
         drive(($urandom_range(3, 0) != 0), a, 2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
         exp_wa = model_stall ? split_wa : req_addr[15:2];
         n_checks++; if (stall_a !== model_stall || ready_a !== !model_stall) begin n_fail++; $display("[TB] FAIL rnd_stall[%0d]: got stall %0b ready %0b expected stall %0b", cyc, stall_a, ready_a, model_stall); end
         n_checks++; if (mem_en_a !== (model_stall | req_valid)) begin n_fail++; $display("[TB] FAIL rnd_mem_en[%0d]: got %0b expected %0b", cyc, mem_en_a, model_stall | req_valid); end
         if (model_stall || req_valid) begin
            n_checks++; if (mem_addr_a !== exp_wa) begin n_fail++; $display("[TB] FAIL rnd_mem_addr[%0d]: got %h expected %h", cyc, mem_addr_a, exp_wa); end
         end
         exp_rv = (pend.size() > 0) && (pend[0].due == cyc);
         if (exp_rv) begin
            r = pend.pop_front();
            exp_last = r.data;
         end
         n_checks++; if (rsp_valid_a !== exp_rv || rsp_data_a !== exp_last) begin n_fail++; $display("[TB] FAIL rnd_rsp[%0d]: got %0b/%h expected %0b/%h", cyc, rsp_valid_a, rsp_data_a, exp_rv, exp_last); end
         if (model_stall) begin
            model_stall = 1'b0;
         end else if (req_valid) begin
            n = (req_size == 2'd0) ? 1 : (req_size == 2'd1) ? 2 : 4;
            r.data = ref_load(req_addr, req_size, req_signed);
            if (int'(req_addr[1:0]) + n > 4) begin
               model_stall = 1'b1;
               split_wa    = req_addr[15:2] + 14'd1;
               r.due       = cyc + 2;
            end else begin
               r.due = cyc + 1;
            end
            pend.push_back(r);
         end
      end
      drive(1'b0, 32'h0, 2'd0, 1'b0);
      drive(1'b0, 32'h0, 2'd0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      for (int i = 0; i < (1 << AW); i++) dmem[i] = $urandom;
      dmem[0]        = 32'h44332211;
      dmem[1]        = 32'h88776655;
      dmem[(1<<AW)-1] = 32'hDDCCBBAA;
      test_reset();
      test_byte_half();
      test_back_to_back();
      test_split();
      test_split_word_wrap();
      test_no_misaligned();
      test_reset_mid_split();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
